// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and slot packing helper for the I2S/TDM transmitter
package i2s_pkg;
  typedef enum logic {I2S_PHILIPS, I2S_LJ} i2s_mode_e;
  typedef enum logic {TX_IDLE, TX_RUN} i2s_tx_state_e;
  localparam int PAD_W = 64;
  // Left-aligns a dw-bit sample in PAD_W bits; the caller keeps the top SLOT_W bits
  function automatic logic [PAD_W-1:0] slot_pad(input logic [PAD_W-1:0] sample, input int dw);
    return sample << (PAD_W - dw);
  endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: show-ahead synchronous FIFO holding whole frames
module i2s_frame_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/i2s_tx_engine.sv
// i2s_tx_engine: single-clock I2S/TDM transmitter with frame FIFO and
// counter-derived MCLK/SCLK/LRCLK.
module i2s_tx_engine
  import i2s_pkg::*;
#(
  parameter int DW         = 24,
  parameter int SLOT_W     = 32,
  parameter int NCH        = 2,
  parameter int SCLK_DIV   = 4,
  parameter int MCLK_LOG2  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          Mode,
  input  logic [NCH*DW-1:0]             sDin,
  input  logic                          sValid,
  output logic                          sReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          MCLK,
  output logic                          SCLK,
  output logic                          LRCLK,
  output logic                          SDATA,
  output logic                          frameStart,
  output logic                          underrun,
  input  logic                          clrUnderrun
);
  localparam int FW = NCH * SLOT_W;
  localparam int BW = $clog2(FW);
  localparam int CW = $clog2(SCLK_DIV);
  i2s_tx_state_e state, state_nx;
  i2s_mode_e mode_q;
  logic [CW-1:0] c, c_nx;
  logic [BW-1:0] b, b_nx;
  logic [MCLK_LOG2-1:0] mclk_cnt;
  logic [FW-1:0] sr, frame_in;
  logic [NCH*DW-1:0] fifo_dout;
  logic fifo_full, fifo_empty, fe, load, lj_bit, dly;

  i2s_frame_fifo #(.W(NCH*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (sValid),
    .pop   (load),
    .din   (sDin),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifoLevel)
  );
  assign sReady = ~fifo_full;
  assign MCLK   = mclk_cnt[MCLK_LOG2-1];

  // An empty FIFO at load time sends a silent frame instead of stale data
  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign frame_in[k*SLOT_W +: SLOT_W] = fifo_empty ? '0 :
      SLOT_W'(slot_pad(PAD_W'(fifo_dout[k*DW +: DW]), DW) >> (PAD_W - SLOT_W));
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= TX_IDLE;
    else state <= state_nx;

  always_comb state_nx = Enable ? TX_RUN : TX_IDLE;

  // Entering RUN counts as a falling event at bit 0, so the first frame loads at once
  always_comb begin
    fe   = Enable & ((state == TX_IDLE) | (c == CW'(SCLK_DIV-1)));
    c_nx = (Enable & (state == TX_RUN) & (c != CW'(SCLK_DIV-1))) ? c + 1'b1 : '0;
    b_nx = (~Enable | (state == TX_IDLE)) ? '0 :
           fe ? ((b == BW'(FW-1)) ? '0 : b + 1'b1) : b;
    load = fe & (b_nx == '0);
  end

  assign lj_bit = load ? frame_in[FW-1] : sr[FW-1];

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      c          <= '0;
      b          <= '0;
      mclk_cnt   <= '0;
      sr         <= '0;
      dly        <= 1'b0;
      mode_q     <= I2S_PHILIPS;
      SCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      SDATA      <= 1'b0;
      frameStart <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      c          <= c_nx;
      b          <= b_nx;
      mclk_cnt   <= mclk_cnt + 1'b1;
      SCLK       <= c_nx >= CW'(SCLK_DIV/2);
      frameStart <= load;
      underrun   <= (load & fifo_empty) | (underrun & ~clrUnderrun);
      if (!Enable) begin
        LRCLK <= 1'b0;
        SDATA <= 1'b0;
        dly   <= 1'b0;
      end else if (fe) begin
        LRCLK <= b_nx >= BW'(NCH/2*SLOT_W);
        SDATA <= ((load ? i2s_mode_e'(Mode) : mode_q) == I2S_LJ) ? lj_bit : dly;
        dly   <= lj_bit;
        sr    <= load ? {frame_in[FW-2:0], 1'b0} : {sr[FW-2:0], 1'b0};
        if (load) mode_q <= i2s_mode_e'(Mode);
      end
    end
endmodule

// File: tb/tb_i2s_tx_engine.sv
// tb_i2s_tx_engine: directed checks of the I2S/TDM transmitter at default parameters
module tb_i2s_tx_engine;
  logic Clk = 1'b0, Reset = 1'b1, Enable = 1'b0, Mode = 1'b0, sValid = 1'b0, clrUnderrun = 1'b0;
  logic [47:0] sDin = '0;
  logic sReady, MCLK, SCLK, LRCLK, SDATA, frameStart, underrun;
  logic [3:0] fifoLevel;
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sd, lr, fs, sh;
  logic ur0;
  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] FS_EXP = 64'h8000_0000_0000_0000;

  i2s_tx_engine dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .Mode        (Mode),
    .sDin        (sDin),
    .sValid      (sValid),
    .sReady      (sReady),
    .fifoLevel   (fifoLevel),
    .MCLK        (MCLK),
    .SCLK        (SCLK),
    .LRCLK       (LRCLK),
    .SDATA       (SDATA),
    .frameStart  (frameStart),
    .underrun    (underrun),
    .clrUnderrun (clrUnderrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Records one 64-bit frame starting at the next falling event; optional actions at given bits
  task automatic capture(input int push_at, input logic [47:0] pd, input int mode_at,
                         input logic mv, input int clr_at);
    for (int b = 0; b < 64; b++) begin
      @(posedge Clk); #1;
      sd[63-b] = SDATA;
      lr[63-b] = LRCLK;
      fs[63-b] = frameStart;
      if (b == 0) ur0 = underrun;
      sValid = 1'b0;
      clrUnderrun = 1'b0;
      if (b == push_at) begin sDin = pd; sValid = 1'b1; end
      if (b == mode_at) Mode = mv;
      if (b == clr_at) clrUnderrun = 1'b1;
      @(posedge Clk); #1;
      sValid = 1'b0;
      clrUnderrun = 1'b0;
      @(posedge Clk); #1;
      sh[63-b] = SCLK;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    logic [63:0] f1, f3, f5, fb;
    logic [7:0] iv;
    f1 = fr(24'hA5A5A5, 24'h3C3C3C);
    f3 = fr(24'h123456, 24'hFEDCBA);
    f5 = fr(24'hC00001, 24'h7FFFFF);
    #2;
    chk("reset_pins", 64'({MCLK, SCLK, LRCLK, SDATA, frameStart, underrun, sReady}), 64'h01);
    chk("reset_level", 64'(fifoLevel), 64'd0);
    #10 Reset = 1'b0;
    @(posedge Clk); #1;
    chk("mclk_lo", 64'(MCLK), 64'd0);
    @(posedge Clk); #1;
    chk("mclk_hi", 64'(MCLK), 64'd1);
    chk("idle_pins", 64'({SCLK, LRCLK, SDATA}), 64'd0);
    sDin = {24'hA5A5A5, 24'h3C3C3C};
    sValid = 1'b1;
    @(posedge Clk); #1;
    sValid = 1'b0;
    chk("level_one", 64'(fifoLevel), 64'd1);
    Enable = 1'b1;
    capture(5, {24'hA5A5A5, 24'h3C3C3C}, 10, 1'b1, -1);
    chk("f1_i2s_sdata", sd, {1'b0, f1[63:1]});
    chk("f1_left_byte", 64'(sd[62:55]), 64'hA5);
    chk("f1_lrclk", lr, LR_EXP);
    chk("f1_framestart", fs, FS_EXP);
    chk("f1_sclk_high", sh, '1);
    capture(3, {24'h123456, 24'hFEDCBA}, 40, 1'b0, -1);
    chk("f2_lj_sdata", sd, f1);
    chk("f2_lrclk", lr, LR_EXP);
    capture(-1, '0, -1, 1'b0, -1);
    chk("f3_i2s_after_toggle", sd, {1'b0, f3[63:1]});
    chk("f3_level_empty", 64'(fifoLevel), 64'd0);
    chk("f3_no_underrun", 64'(underrun), 64'd0);
    capture(-1, '0, -1, 1'b0, -1);
    chk("f4_underrun", 64'(ur0), 64'd1);
    chk("f4_zero_sdata", sd, 64'd0);
    chk("f4_framestart", fs, FS_EXP);
    sDin = {24'hC00001, 24'h7FFFFF};
    sValid = 1'b1;
    clrUnderrun = 1'b1;
    capture(-1, '0, -1, 1'b0, 20);
    chk("f5_set_beats_clear", 64'(ur0), 64'd1);
    chk("f5_no_bypass", sd, 64'd0);
    chk("f5_level", 64'(fifoLevel), 64'd1);
    chk("f5_cleared", 64'(underrun), 64'd0);
    capture(-1, '0, -1, 1'b0, -1);
    chk("f6_sdata", sd, {1'b0, f5[63:1]});
    Enable = 1'b0;
    @(posedge Clk); #1;
    chk("disable_pins", 64'({SCLK, LRCLK, SDATA}), 64'd0);
    chk("disable_level", 64'(fifoLevel), 64'd0);
    for (int i = 0; i < 9; i++) begin
      iv = 8'(i);
      sDin = {iv, 16'h5A5A, 16'hC3C3, iv};
      sValid = 1'b1;
      @(posedge Clk); #1;
    end
    sValid = 1'b0;
    chk("full_level", 64'(fifoLevel), 64'd8);
    chk("full_ready", 64'(sReady), 64'd0);
    Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv = 8'(i);
      fb = fr({iv, 16'h5A5A}, {16'hC3C3, iv});
      capture(-1, '0, -1, 1'b0, -1);
      chk($sformatf("batch%0d_sdata", i), sd, {1'b0, fb[63:1]});
    end
    chk("batch_level", 64'(fifoLevel), 64'd0);
    capture(-1, '0, -1, 1'b0, -1);
    chk("ninth_dropped_underrun", 64'(ur0), 64'd1);
    chk("ninth_dropped_sdata", sd, 64'd0);
    sDin = {24'hA5A5A5, 24'h3C3C3C};
    sValid = 1'b1;
    @(posedge Clk); #1;
    sValid = 1'b0;
    repeat (6) @(posedge Clk);
    #2;
    chk("pre_reset", 64'({fifoLevel, SCLK, underrun}), 64'({4'd1, 1'b1, 1'b1}));
    Reset = 1'b1;
    #1;
    chk("midframe_reset_pins", 64'({MCLK, SCLK, LRCLK, SDATA, frameStart, underrun, sReady}), 64'h01);
    chk("midframe_reset_level", 64'(fifoLevel), 64'd0);
    #10 Reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
